// File: rtl/tlb_maint_ctrl_pkg.sv
// tlb_maint_ctrl_pkg
// Shared types and constants for the TLB maintenance controller: request op
// encodings, FSM state encoding, TLB entry field layout and the invtlb opcode
// validity helper.
package tlb_maint_ctrl_pkg;

  localparam int unsigned ENTRY_W = 89;

  // Page size (log2) of a huge page; huge pages compare only vppn[18:9].
  localparam logic [5:0] PS_HUGE = 6'd21;

  // Highest invtlb opcode that performs a scan; anything above raises ine.
  localparam logic [4:0] INV_OP_MAX = 5'd6;

  typedef enum logic [1:0] {
    OpWr   = 2'd0,
    OpFill = 2'd1,
    OpInv  = 2'd2
  } req_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StScan  = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  function automatic logic inv_op_valid(input logic [4:0] op);
    return op <= INV_OP_MAX;
  endfunction

endpackage

// File: rtl/tlb_maint_ctrl_if.sv
// tlb_maint_ctrl_if
// Bundles the maintenance request handshake (writeback side) and the TLB
// read/write port (array side) of the maintenance controller.
//   master : drives requests and TLB read data (writeback stage + TLB array)
//   slave  : the controller itself
interface tlb_maint_ctrl_if
  import tlb_maint_ctrl_pkg::*;
#(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned IDXW   = $clog2(TLBNUM)
) ();

  // Request side
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [IDXW-1:0]    req_index;
  logic [ENTRY_W-1:0] req_entry;
  logic [4:0]         inv_op;
  logic [9:0]         inv_asid;
  logic [18:0]        inv_vppn;

  // TLB array side
  logic [IDXW-1:0]    r_index;
  logic [ENTRY_W-1:0] r_entry;
  logic               we;
  logic [IDXW-1:0]    w_index;
  logic [ENTRY_W-1:0] w_entry;

  // Status
  logic               busy;
  logic               done;
  logic               ine;

  modport master (
    output req_valid, req_op, req_index, req_entry, inv_op, inv_asid, inv_vppn, r_entry,
    input  req_ready, r_index, we, w_index, w_entry, busy, done, ine
  );

  modport slave (
    input  req_valid, req_op, req_index, req_entry, inv_op, inv_asid, inv_vppn, r_entry,
    output req_ready, r_index, we, w_index, w_entry, busy, done, ine
  );

endinterface

// File: rtl/tlb_inv_match.sv
// tlb_inv_match
// Combinational invtlb match of one TLB entry against the latched invtlb
// opcode / ASID / VA. Only valid entries (e=1) can match.
//   i_e, i_g, i_asid, i_vppn, i_ps : fields of the entry being scanned
//   i_inv_op, i_inv_asid, i_inv_vppn : invtlb operands
//   o_match : entry must be invalidated
module tlb_inv_match
  import tlb_maint_ctrl_pkg::*;
(
  input  logic        i_e,
  input  logic        i_g,
  input  logic [9:0]  i_asid,
  input  logic [18:0] i_vppn,
  input  logic [5:0]  i_ps,
  input  logic [4:0]  i_inv_op,
  input  logic [9:0]  i_inv_asid,
  input  logic [18:0] i_inv_vppn,
  output logic        o_match
);

  logic w_asid_hit;
  logic w_va_hit;

  assign w_asid_hit = (i_asid == i_inv_asid);
  // Huge pages ignore the low vppn bits that fall inside the page.
  assign w_va_hit   = (i_ps == PS_HUGE) ? (i_vppn[18:9] == i_inv_vppn[18:9])
                                        : (i_vppn == i_inv_vppn);

  always_comb begin
    o_match = 1'b0;
    if (i_e) begin
      case (i_inv_op)
        5'd0, 5'd1: o_match = 1'b1;
        5'd2:       o_match = i_g;
        5'd3:       o_match = ~i_g;
        5'd4:       o_match = ~i_g & w_asid_hit;
        5'd5:       o_match = ~i_g & w_asid_hit & w_va_hit;
        5'd6:       o_match = (i_g | w_asid_hit) & w_va_hit;
        default:    o_match = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/tlb_maint_ctrl.sv
// tlb_maint_ctrl
// Executes TLB maintenance requests from writeback:
//   WR   : write req_entry at req_index
//   FILL : write req_entry at a pseudo-random index (free-running counter)
//   INV  : scan every entry and clear e on those matching the invtlb operands;
//          opcodes above 6 complete immediately with ine=1
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   bus       : request handshake, TLB read/write port, busy/done/ine status
module tlb_maint_ctrl
  import tlb_maint_ctrl_pkg::*;
#(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
  input logic              clk,
  input logic              rstn,
  tlb_maint_ctrl_if.slave  bus
);

  localparam logic [IDXW-1:0] LastIdx = IDXW'(TLBNUM - 1);

  state_e          r_state;
  logic [IDXW-1:0] r_scan_idx;
  logic [IDXW-1:0] r_fill_cnt;
  logic [IDXW-1:0] r_req_index;
  tlb_entry_t      r_req_entry;
  logic [4:0]      r_inv_op;
  logic [9:0]      r_inv_asid;
  logic [18:0]     r_inv_vppn;
  logic            r_req_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_ine;

  tlb_entry_t      w_rd_entry;
  tlb_entry_t      w_clr_entry;
  logic            w_match;

  assign w_rd_entry = bus.r_entry;

  always_comb begin
    w_clr_entry   = w_rd_entry;
    w_clr_entry.e = 1'b0;
  end

  tlb_inv_match u_inv_match (
    .i_e        (w_rd_entry.e),
    .i_g        (w_rd_entry.g),
    .i_asid     (w_rd_entry.asid),
    .i_vppn     (w_rd_entry.vppn),
    .i_ps       (w_rd_entry.ps),
    .i_inv_op   (r_inv_op),
    .i_inv_asid (r_inv_asid),
    .i_inv_vppn (r_inv_vppn),
    .o_match    (w_match)
  );

  // FSM with registered status outputs; done/ine are one-cycle pulses that
  // are set on entry to StDone and dropped by default on the next edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_scan_idx  <= '0;
      r_fill_cnt  <= '0;
      r_req_index <= '0;
      r_req_entry <= '0;
      r_inv_op    <= '0;
      r_inv_asid  <= '0;
      r_inv_vppn  <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ine       <= 1'b0;
    end else begin
      r_fill_cnt <= r_fill_cnt + IDXW'(1);
      r_done     <= 1'b0;
      r_ine      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.req_valid) begin
            r_req_index <= (bus.req_op == OpFill) ? r_fill_cnt : bus.req_index;
            r_req_entry <= bus.req_entry;
            r_inv_op    <= bus.inv_op;
            r_inv_asid  <= bus.inv_asid;
            r_inv_vppn  <= bus.inv_vppn;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (bus.req_op == OpWr || bus.req_op == OpFill) begin
              r_state <= StWrite;
            end else if (bus.req_op == OpInv && inv_op_valid(bus.inv_op)) begin
              r_state    <= StScan;
              r_scan_idx <= '0;
            end else begin
              // Invalid invtlb opcode, or the unused op encoding (no ine).
              r_state <= StDone;
              r_done  <= 1'b1;
              r_ine   <= (bus.req_op == OpInv);
            end
          end
        end
        StWrite: begin
          r_state <= StDone;
          r_done  <= 1'b1;
        end
        StScan: begin
          if (r_scan_idx == LastIdx) begin
            r_state    <= StDone;
            r_done     <= 1'b1;
            r_scan_idx <= '0;
          end else begin
            r_scan_idx <= r_scan_idx + IDXW'(1);
          end
        end
        StDone: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // TLB port. The scan write depends on the combinational read data, so it
  // cannot be registered. Writes are suppressed while reset is asserted so a
  // reset landing mid-scan cannot corrupt the array on that edge.
  always_comb begin
    bus.we      = 1'b0;
    bus.w_index = '0;
    bus.w_entry = '0;
    bus.r_index = '0;
    unique case (r_state)
      StWrite: begin
        bus.we      = rstn;
        bus.w_index = r_req_index;
        bus.w_entry = r_req_entry;
      end
      StScan: begin
        bus.r_index = r_scan_idx;
        bus.w_index = r_scan_idx;
        bus.w_entry = w_clr_entry;
        bus.we      = rstn & w_match;
      end
      default: begin
      end
    endcase
  end

  assign bus.req_ready = r_req_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.ine       = r_ine;

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
module tb_tlb_maint_ctrl;
  import tlb_maint_ctrl_pkg::*;

  localparam int unsigned TLBNUM = 16;
  localparam int unsigned IDXW   = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  tlb_maint_ctrl_if #(.TLBNUM(TLBNUM), .IDXW(IDXW)) bus ();

  tlb_maint_ctrl #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Behavioural TLB array
  tlb_entry_t mem [TLBNUM];
  always @(posedge clk) if (bus.we) mem[bus.w_index] <= bus.w_entry;
  assign bus.r_entry = mem[bus.r_index];

  int unsigned ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  // Fill counter as seen by the reference: cycles since reset, modulo TLBNUM.
  logic [IDXW-1:0] mcnt;
  always @(posedge clk) if (!rstn) mcnt <= '0; else mcnt <= mcnt + IDXW'(1);

  typedef struct { logic [IDXW-1:0] idx; tlb_entry_t ent; int unsigned cyc; } wr_t;
  typedef struct { bit ine; int unsigned cyc; } dn_t;
  wr_t exp_w[$];
  dn_t exp_d[$];
  int unsigned busy_lo = 1, busy_hi = 0;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  function automatic bit model_match(tlb_entry_t t, logic [4:0] op, logic [9:0] asid,
                                     logic [18:0] vppn);
    bit va_ok, as_ok;
    if (t.ps == 6'd21) va_ok = (t.vppn >> 9) == (vppn >> 9);
    else               va_ok = t.vppn == vppn;
    as_ok = t.asid == asid;
    if (!t.e) return 0;
    if (op <= 1) return 1;
    if (op == 2) return t.g;
    if (op == 3) return !t.g;
    if (op == 4) return !t.g && as_ok;
    if (op == 5) return !t.g && as_ok && va_ok;
    if (op == 6) return (t.g || as_ok) && va_ok;
    return 0;
  endfunction

  function automatic logic [18:0] pick_vppn();
    case ($urandom % 4)
      0:       return 19'h40000;
      1:       return 19'h401FF;
      2:       return 19'h40001;
      default: return 19'h12345;
    endcase
  endfunction

  function automatic logic [9:0] pick_asid();
    return ($urandom % 2) ? 10'h12 : 10'h55;
  endfunction

  function automatic tlb_entry_t rand_entry();
    tlb_entry_t t;
    logic [95:0] r;
    r      = {$urandom(), $urandom(), $urandom()};
    t      = r[88:0];
    t.e    = ($urandom % 4) != 0;
    t.g    = $urandom % 2;
    t.asid = pick_asid();
    t.vppn = pick_vppn();
    t.ps   = ($urandom % 2) ? 6'd21 : 6'd12;
    return t;
  endfunction

  // Monitor: compares every DUT action against the scoreboard.
  bit  m_busy;
  wr_t m_w;
  dn_t m_d;
  always @(negedge clk) begin
    if (rstn) begin
      m_busy = (ncyc >= busy_lo) && (ncyc <= busy_hi);
      chk("req_ready", bus.req_ready, !m_busy);
      chk("busy", bus.busy, m_busy);
      if (!m_busy) begin
        chk("idle_r_index", bus.r_index, 0);
        chk("idle_w_index", bus.w_index, 0);
        chk("idle_w_entry", bus.w_entry, 0);
      end
      if (bus.we) begin
        if (exp_w.size() == 0) chk("unexpected_we", bus.we, 0);
        else begin
          m_w = exp_w.pop_front();
          chk("w_index", bus.w_index, m_w.idx);
          chk("w_entry", bus.w_entry, m_w.ent);
          chk("we_cycle", ncyc, m_w.cyc);
        end
      end
      if (bus.done) begin
        if (exp_d.size() == 0) chk("unexpected_done", bus.done, 0);
        else begin
          m_d = exp_d.pop_front();
          chk("ine", bus.ine, m_d.ine);
          chk("done_cycle", ncyc, m_d.cyc);
        end
      end else begin
        chk("ine_without_done", bus.ine, 0);
      end
    end
  end

  task automatic scramble();
    tlb_entry_t t;
    t             = rand_entry();
    bus.req_op    = 2'($urandom);
    bus.req_index = IDXW'($urandom);
    bus.req_entry = t;
    bus.inv_op    = 5'($urandom);
    bus.inv_asid  = 10'($urandom);
    bus.inv_vppn  = 19'($urandom);
  endtask

  // Call at #1 after a posedge. Waits for ready, issues, pushes expectations.
  task automatic issue(input logic [1:0] op, input logic [IDXW-1:0] idx, input tlb_entry_t ent,
                       input logic [4:0] iop, input logic [9:0] asid, input logic [18:0] vppn);
    int g = 0;
    int unsigned acc, lat;
    wr_t w;
    dn_t d;
    tlb_entry_t t;
    while (bus.req_ready !== 1'b1 && g < 100) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 100) begin
      chk("ready_timeout", bus.req_ready, 1);
      summary();
      $finish;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_index = idx;
    bus.req_entry = ent;
    bus.inv_op    = iop;
    bus.inv_asid  = asid;
    bus.inv_vppn  = vppn;
    @(negedge clk);
    acc = ncyc;
    if (op == OpWr || op == OpFill) begin
      w.idx = (op == OpFill) ? mcnt : idx;
      w.ent = ent;
      w.cyc = acc + 1;
      exp_w.push_back(w);
      lat = 2;
    end else if (iop <= 6) begin
      for (int i = 0; i < TLBNUM; i++) begin
        t = mem[i];
        if (model_match(t, iop, asid, vppn)) begin
          t.e   = 1'b0;
          w.idx = IDXW'(i);
          w.ent = t;
          w.cyc = acc + 1 + i;
          exp_w.push_back(w);
        end
      end
      lat = TLBNUM + 1;
    end else begin
      lat = 1;
    end
    d.ine = (op == OpInv) && (iop > 6);
    d.cyc = acc + lat;
    exp_d.push_back(d);
    busy_lo = acc + 1;
    busy_hi = acc + lat;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    scramble();
  endtask

  task automatic wr(input int i, input tlb_entry_t e);
    issue(OpWr, IDXW'(i), e, 5'd0, 10'd0, 19'd0);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((bus.req_ready !== 1'b1 || exp_d.size() != 0) && g < 100) begin
      @(posedge clk); #1; g++;
    end
    chk("idle_timeout", g < 100, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    tlb_entry_t e, ea, eb;
    int g, cnt;
    logic [1:0] op;
    bus.req_valid = 1'b0;
    scramble();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Populate the whole array through WR requests
    for (int i = 0; i < TLBNUM; i++) wr(i, rand_entry());

    // WR to index 5
    e = rand_entry();
    e.e = 1'b1;
    wr(5, e);

    // FILL accepted while the counter is at its top value
    g = 0;
    while (!(mcnt == IDXW'(TLBNUM - 1) && bus.req_ready === 1'b1) && g < 100) begin
      @(posedge clk); #1; g++;
    end
    chk("fill_align_timeout", g < 100, 1);
    issue(OpFill, '0, rand_entry(), 5'd0, 10'd0, 19'd0);
    issue(OpFill, '0, rand_entry(), 5'd0, 10'd0, 19'd0);

    // INV op2 with only entries 3 and 9 global
    for (int i = 0; i < TLBNUM; i++) begin
      e = rand_entry();
      e.e = 1'b1;
      e.g = (i == 3 || i == 9);
      wr(i, e);
    end
    issue(OpInv, '0, '0, 5'd2, 10'd0, 19'd0);

    // INV op5: huge-page entry A matches on vppn[18:9], 4K entry B does not
    for (int i = 2; i < TLBNUM; i++) begin
      e = rand_entry();
      e.e = 1'b1;
      e.g = 1'b1;
      wr(i, e);
    end
    ea = rand_entry();
    ea.e = 1'b1; ea.g = 1'b0; ea.asid = 10'h12; ea.ps = 6'd21; ea.vppn = 19'h401FF;
    eb = ea;
    eb.ps = 6'd12; eb.vppn = 19'h40001;
    wr(0, ea);
    wr(1, eb);
    issue(OpInv, '0, '0, 5'd5, 10'h12, 19'h40000);
    wait_idle();
    chk("op5_A_invalidated", mem[0].e, 0);
    chk("op5_B_kept", mem[1].e, 1);
    cnt = 0;
    for (int i = 2; i < TLBNUM; i++) cnt += mem[i].e;
    chk("op5_global_kept", cnt, TLBNUM - 2);

    // Invalid opcode
    issue(OpInv, '0, '0, 5'd7, 10'd0, 19'd0);

    // Reset at scan index 4 of an op0 scan
    for (int i = 0; i < TLBNUM; i++) begin
      e = rand_entry();
      e.e = (i != 4);
      wr(i, e);
    end
    issue(OpInv, '0, '0, 5'd0, 10'd0, 19'd0);
    repeat (4) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst_pending_writes", exp_w.size(), TLBNUM - 5);
    chk("rst_pending_done", exp_d.size(), 1);
    exp_w.delete();
    exp_d.delete();
    busy_lo = 1;
    busy_hi = 0;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic
    for (int n = 0; n < 50; n++) begin
      case ($urandom % 8)
        0, 1, 2: op = OpWr;
        3, 4:    op = OpFill;
        default: op = OpInv;
      endcase
      issue(op, IDXW'($urandom), rand_entry(), 5'($urandom % 10), pick_asid(), pick_vppn());
    end

    wait_idle();
    chk("left_writes", exp_w.size(), 0);
    chk("left_dones", exp_d.size(), 0);
    summary();
    $finish;
  end

endmodule

// File: doc/tlb_maint_ctrl.md
TLB_MAINT_CTRL -- requirements
Module: tlb_maint_ctrl

Interface
REQ-001 Parameters (name, default, meaning): TLBNUM, 16, TLB entry count, power of two; IDXW, $clog2(TLBNUM), index width.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- req_valid  in  1  maintenance request from writeback.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  operation: WR=0, FILL=1, INV=2.
- req_index  in  IDXW  target index for WR.
- req_entry  in  ENTRY_W  entry image for WR/FILL.
- inv_op  in  5  invtlb opcode.
- inv_asid  in  10  invtlb ASID.
- inv_vppn  in  19  invtlb VA[31:13].
- r_index  out  IDXW  scan read index.
- r_entry  in  ENTRY_W  combinational TLB read data at r_index.
- we  out  1  TLB write strobe.
- w_index  out  IDXW  TLB write index.
- w_entry  out  ENTRY_W  TLB write data.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- ine  out  1  valid with done; invalid invtlb opcode.

Function
REQ-003 FSM states: IDLE, WRITE, SCAN, DONE.
REQ-004 req_ready = 1 only in IDLE; a request is accepted on req_valid && req_ready, and all request fields are latched on acceptance.
REQ-005 IDLE -> WRITE on accepted WR or FILL; WRITE -> DONE after exactly one cycle with we=1.
REQ-006 WR: w_index = latched req_index; w_entry = latched req_entry.
REQ-007 FILL index source:
- free-running IDXW-bit counter, incremented every cycle after reset, wraps TLBNUM-1 -> 0.
- w_index = counter value sampled at acceptance.
REQ-008 INV with inv_op <= 6: IDLE -> SCAN, scan index starts at 0.
REQ-009 INV with inv_op >= 7: IDLE -> DONE, no TLB write, ine=1 during DONE.
REQ-010 SCAN cycle behaviour:
- r_index = scan index.
- if the entry matches, we=1, w_index = scan index, w_entry = r_entry with e cleared, all other fields unchanged.
- scan index increments each cycle; after index TLBNUM-1 the FSM goes to DONE.
REQ-011 Match rules (entry has e=1; otherwise no write):
- op0, op1: all entries.
- op2: g=1.
- op3: g=0.
- op4: g=0 && asid==inv_asid.
- op5: g=0 && asid==inv_asid && VA match.
- op6: (g=1 || asid==inv_asid) && VA match.
REQ-012 VA match: entry ps==21 compares vppn[18:9]; any other ps compares vppn[18:0].
REQ-013 Latency from acceptance to done:
- WR/FILL: 2 cycles.
- INV valid: TLBNUM+1 cycles.
- INV invalid: 1 cycle.
REQ-014 DONE -> IDLE after one cycle; done=1 only in DONE; no request is accepted in the DONE cycle.
REQ-015 Outside WRITE/SCAN, we=0; w_index, w_entry and r_index hold 0 in IDLE.
REQ-016 An accepted request always runs to completion; there is no abort input.

Reset
REQ-017 When rstn=0 at a clk edge:
- state=IDLE, scan index=0, fill counter=0, all latched fields=0.
- outputs: we=0, done=0, ine=0, busy=0; req_ready=1 from the first cycle after reset.
REQ-018 Reset asserted mid-SCAN returns the FSM to IDLE on that edge, with no further writes.

Structure
REQ-019 Shared package holds:
- op encodings (WR/FILL/INV), FSM state encoding.
- entry field layout {e, vppn[18:0], ps[5:0], asid[9:0], g, ppn0[19:0], plv0[1:0], mat0[1:0], d0, v0, ppn1[19:0], plv1[1:0], mat1[1:0], d1, v1}.
- ENTRY_W = 89.
REQ-020 One sub-module, tlb_inv_match: combinational match of r_entry against inv_op/inv_asid/inv_vppn.

Verification
REQ-021 WR, index=5, entry e=1 -> we=1 at cycle 1 with w_index=5 and w_entry equal; done at cycle 2; req_ready=0 at cycles 1-2.
REQ-022 FILL accepted when the counter is 15 (TLBNUM=16) -> w_index=15; the counter reads 0 on the next cycle.
REQ-023 INV op2 with entries 3 and 9 having g=1 -> exactly two writes (idx 3, 9, e=0); done 17 cycles after acceptance.
REQ-024 INV op5, asid=0x12, vppn=0x40000 -> of entry A (ps=21, vppn=0x401FF, g=0) and entry B (ps=12, vppn=0x40001), only A is invalidated; g=1 entries are untouched.
REQ-025 INV op7 -> done and ine=1 one cycle after acceptance, we never asserted.
REQ-026 rstn=0 at scan index 4 of an op0 scan -> no writes thereafter; IDLE and req_ready=1 next cycle.
